mult_share_sched: RTL and testbench
===================================

# mult_share_sched

Round-robin scheduler that shares one combinational 32x32 multiplier and one HI/LO result register pair between LANES requesting lanes of the 4-lane datapath. It grants one lane at a time and drives the multiplier operands and enable for a programmable number of settle cycles. It then captures the 64-bit product into HI/LO and pulses a per-lane completion strobe. It sits between the lane register-file read ports (rs/rt) and the shared multiplier instance.

## Interface
- LANES, 4, number of requesting lanes (2..8)
- LAT, 3, cycles the multiplier enable/operands are held before the product is sampled (>=1)

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous abort of any pending/in-flight operation
- req  in  LANES  per-lane level request; lane holds req and operands until granted
- a_in  in  32*LANES  lane i operand A (rs) at bits [32i+31:32i]
- b_in  in  32*LANES  lane i operand B (rt) at bits [32i+31:32i]
- gnt  out  LANES  one-hot grant, combinational, valid only in IDLE
- mul_en  out  1  enable to shared multiplier
- mul_a  out  32  operand A to multiplier (registered)
- mul_b  out  32  operand B to multiplier (registered)
- mul_y  in  64  multiplier product {high, low}
- hi  out  32  HI register
- lo  out  32  LO register
- done  out  LANES  one-hot completion pulse, one cycle
- busy  out  1  high in BUSY and DONE

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if flush=0 and req!=0, winner = first set req bit searching upward from ptr, wrapping modulo LANES. gnt[winner]=1 in the same cycle. At the clock edge: latch a_in/b_in of winner into mul_a/mul_b, owner<=winner, ptr<=(winner+1) mod LANES, cnt<=LAT-1, go BUSY. If req=0 or flush=1: gnt=0, stay.
- Requester samples gnt=1 and may drop or change req/operands from the next cycle.
- BUSY: mul_en=1, operands held. If flush=1: go IDLE, mul_en deasserts next cycle, no done, hi/lo unchanged, ptr keeps its post-grant value. Otherwise if cnt==0: hi<=mul_y[63:32], lo<=mul_y[31:0], go DONE. Otherwise cnt<=cnt-1.
- DONE: done[owner]=1 for exactly this cycle; mul_en=0. Unconditionally go IDLE. flush has no effect. No arbitration in DONE.
- hi/lo hold the last completed product until the next completion; they never change on grant or flush.
- mul_a/mul_b retain their last latched values outside BUSY.
- cnt width = max(1, clog2(LAT)). Wrap of ptr from LANES-1 to 0 is modulo.
- Only one op is in flight; gnt is never asserted outside IDLE.

## Timing
- Reset (rst=0, immediate): state IDLE, ptr=0, owner=0, cnt=0, mul_a=mul_b=0, hi=lo=0, mul_en=0, done=0, busy=0; gnt=0 while rst is low.
- Reset mid-BUSY aborts the op; no done is produced.
- Cycle 0: grant (IDLE). Cycles 1..LAT: BUSY, mul_en=1. hi/lo update at the end of cycle LAT. Cycle LAT+1: DONE, done pulse, new hi/lo visible.
- Earliest next grant is cycle LAT+2, so throughput is 1 op per LAT+2 cycles.
- done and busy are decoded from registered state (glitch-free). gnt is a combinational function of req, ptr, state and flush.

## Test plan
- Reset: assert rst=0 mid-BUSY with LAT=3. Required: all outputs zero immediately. After release with req=0, state stays IDLE, gnt=0.
- Single op: lane 2, a=0x0001_0000, b=0x0001_0000, req[2] high at cycle 0. Required: gnt=0100 at cycle 0; mul_en high cycles 1-3; done=0100 at cycle 4 with hi=0x0000_0001, lo=0x0000_0000; busy high cycles 1-4.
- Round-robin: all four req held high continuously, ptr=0 after reset. Required: grants in order lane 0,1,2,3,0 at cycles 0,5,10,15,20. Each done pulse fires 4 cycles after its grant, to the matching lane.
- Wrap: ptr=3 (after a lane-2 grant), req=1001. Required: next grant is lane 3, then lane 0.
- Flush in BUSY: lane 1 granted with a=7, b=6 while hi/lo=0x5/0x9 from a prior op; flush at cycle 2. Required: IDLE at cycle 3, no done, hi=0x5, lo=0x9. Flush in IDLE with req set gives gnt=0.
- Max values: a=b=0xFFFF_FFFF on lane 0, with multiplier stub returning the unsigned product. Required: hi=0xFFFF_FFFE, lo=0x0000_0001 at done.

Source files
------------

// File: rtl/mult_share_sched.sv
// mult_share_sched: round-robin arbiter that time-shares one combinational
// 32x32 multiplier and a HI/LO result pair among LANES requesting lanes.
// A granted lane's operands are latched, held on the multiplier for LAT
// cycles, then the 64-bit product is captured into HI/LO and the owning
// lane receives a one-cycle done strobe.
module mult_share_sched #(
    parameter int LANES = 4,
    parameter int LAT   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [LANES-1:0]      req,
    input  logic [32*LANES-1:0]   a_in,
    input  logic [32*LANES-1:0]   b_in,
    output logic [LANES-1:0]      gnt,
    output logic                  mul_en,
    output logic [31:0]           mul_a,
    output logic [31:0]           mul_b,
    input  logic [63:0]           mul_y,
    output logic [31:0]           hi,
    output logic [31:0]           lo,
    output logic [LANES-1:0]      done,
    output logic                  busy
);

    localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CW = (LAT > 2) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);
    localparam logic [PW-1:0] LAST_LANE = PW'(LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_owner;
    logic [CW-1:0]      r_cnt;
    logic [31:0]        r_mul_a;
    logic [31:0]        r_mul_b;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic               r_mul_en;
    logic [LANES-1:0]   r_done;
    logic               r_busy;

    logic               w_found;
    logic [PW-1:0]      w_win;
    logic [31:0]        w_a;
    logic [31:0]        w_b;
    logic               w_grant;
    logic [PW-1:0]      w_next_ptr;

    // Search upward from r_ptr with wrap; first requesting lane wins.
    always_comb begin
        int unsigned idx;
        w_found = 1'b0;
        w_win   = '0;
        w_a     = '0;
        w_b     = '0;
        idx     = 0;
        for (int unsigned k = 0; k < LANES; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= LANES) begin
                idx = idx - LANES;
            end
            if (!w_found && req[idx]) begin
                w_found = 1'b1;
                w_win   = PW'(idx);
                w_a     = a_in[32*idx +: 32];
                w_b     = b_in[32*idx +: 32];
            end
        end
    end

    // Grant is only offered in IDLE, out of reset, and when not flushing.
    always_comb begin
        w_grant    = (r_state == S_IDLE) && rst && !flush && w_found;
        w_next_ptr = (w_win == LAST_LANE) ? '0 : w_win + 1'b1;
        gnt        = w_grant ? (LANES'(1) << w_win) : '0;
    end

    // Scheduler FSM; mul_en, busy and done are registered alongside state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_owner  <= '0;
            r_cnt    <= '0;
            r_mul_a  <= '0;
            r_mul_b  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_mul_en <= 1'b0;
            r_done   <= '0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_mul_a  <= w_a;
                        r_mul_b  <= w_b;
                        r_owner  <= w_win;
                        r_ptr    <= w_next_ptr;
                        r_cnt    <= CNT_INIT;
                        r_mul_en <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (flush) begin
                        r_mul_en <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else if (r_cnt == '0) begin
                        r_hi     <= mul_y[63:32];
                        r_lo     <= mul_y[31:0];
                        r_mul_en <= 1'b0;
                        r_done   <= LANES'(1) << r_owner;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_mul_en <= 1'b0;
                    r_done   <= '0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign mul_en = r_mul_en;
    assign mul_a  = r_mul_a;
    assign mul_b  = r_mul_b;
    assign hi     = r_hi;
    assign lo     = r_lo;
    assign done   = r_done;
    assign busy   = r_busy;

endmodule

// File: tb/tb_mult_share_sched.sv
// Testbench for mult_share_sched: scoreboard-based, randomized operands and
// request masks against a round-robin reference model.
module tb_mult_share_sched;

    localparam int LANES = 4;
    localparam int LAT   = 3;

    logic                 clk;
    logic                 rst;
    logic                 flush;
    logic [LANES-1:0]     req;
    logic [32*LANES-1:0]  a_in;
    logic [32*LANES-1:0]  b_in;
    logic [LANES-1:0]     gnt;
    logic                 mul_en;
    logic [31:0]          mul_a;
    logic [31:0]          mul_b;
    logic [63:0]          mul_y;
    logic [31:0]          hi;
    logic [31:0]          lo;
    logic [LANES-1:0]     done;
    logic                 busy;

    mult_share_sched #(.LANES(LANES), .LAT(LAT)) dut (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .req    (req),
        .a_in   (a_in),
        .b_in   (b_in),
        .gnt    (gnt),
        .mul_en (mul_en),
        .mul_a  (mul_a),
        .mul_b  (mul_b),
        .mul_y  (mul_y),
        .hi     (hi),
        .lo     (lo),
        .done   (done),
        .busy   (busy)
    );

    // Combinational multiplier stub: unsigned 32x32 product.
    assign mul_y = 64'(mul_a) * 64'(mul_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          lane;
        logic [63:0] prod;
        int          gcyc;
    } item_t;

    item_t       sbq[$];
    int          n_pass = 0;
    int          n_tot  = 0;
    int          m_ptr  = 0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    int          last_g = -1;
    int          en_cnt = 0;
    logic [31:0] la[LANES];
    logic [31:0] lb[LANES];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference arbitration: first requesting lane at or after p, wrapping.
    function automatic int pick(input logic [LANES-1:0] m, input int p);
        int l;
        for (int k = 0; k < LANES; k++) begin
            l = (p + k) % LANES;
            if (m[l]) return l;
        end
        return -1;
    endfunction

    task automatic drive_ops();
        for (int l = 0; l < LANES; l++) begin
            a_in[32*l +: 32] = la[l];
            b_in[32*l +: 32] = lb[l];
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("wait_idle_timeout", 64'(busy), 64'(0));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("drain_timeout", 64'(sbq.size()), 64'(0));
    endtask

    // Issue one op at a negedge in IDLE; returns at the negedge of cycle 1.
    task automatic do_op(input logic [LANES-1:0] mask, input bit hold, input bit rnd);
        int    w;
        item_t it;
        wait_idle();
        if (rnd) begin
            for (int l = 0; l < LANES; l++) begin
                la[l] = $urandom;
                lb[l] = $urandom;
            end
        end
        flush = 1'b0;
        req   = mask;
        drive_ops();
        #1;
        w = pick(mask, m_ptr);
        chk("gnt", 64'(gnt), 64'(LANES'(1) << w));
        if (hold && last_g >= 0) chk("rr_spacing", 64'(cyc - last_g), 64'(LAT + 2));
        it.lane = w;
        it.prod = 64'(la[w]) * 64'(lb[w]);
        it.gcyc = cyc;
        sbq.push_back(it);
        m_ptr  = (w + 1) % LANES;
        last_g = hold ? cyc : -1;
        @(negedge clk);
        if (!hold) req = '0;
        chk("mul_a_latched", 64'(mul_a), 64'(la[w]));
        chk("mul_b_latched", 64'(mul_b), 64'(lb[w]));
    endtask

    // Monitor: compares every done pulse against the scoreboard head.
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            if (mul_en === 1'b1) en_cnt++;
            else if (done === '0) en_cnt = 0;
            if (done !== '0) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'(0));
                end else begin
                    it = sbq.pop_front();
                    chk("done_lane", 64'(done), 64'(LANES'(1) << it.lane));
                    chk("hi", 64'(hi), 64'(it.prod[63:32]));
                    chk("lo", 64'(lo), 64'(it.prod[31:0]));
                    chk("done_latency", 64'(cyc - it.gcyc), 64'(LAT + 1));
                    chk("mul_en_cycles", 64'(en_cnt), 64'(LAT));
                    chk("busy_at_done", 64'(busy), 64'(1));
                    m_hi = it.prod[63:32];
                    m_lo = it.prod[31:0];
                end
                en_cnt = 0;
            end
        end
    end

    initial begin
        logic [31:0] ph, pl;
        int          w;
        rst   = 1'b0;
        flush = 1'b0;
        req   = '0;
        a_in  = '0;
        b_in  = '0;
        for (int l = 0; l < LANES; l++) begin
            la[l] = '0;
            lb[l] = '0;
        end
        #1;
        chk("reset_busy",   64'(busy),   64'(0));
        chk("reset_mul_en", 64'(mul_en), 64'(0));
        chk("reset_hi",     64'(hi),     64'(0));
        chk("reset_done",   64'(done),   64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Round-robin with all lanes requesting continuously: 0,1,2,3,0.
        last_g = -1;
        for (int n = 0; n < 5; n++) do_op(4'b1111, 1'b1, 1'b1);
        req = '0;

        // Single op on lane 2: 0x10000 * 0x10000 = 0x1_0000_0000.
        la[2] = 32'h0001_0000;
        lb[2] = 32'h0001_0000;
        do_op(4'b0100, 1'b0, 1'b0);
        wait_drain();
        chk("single_hi", 64'(hi), 64'h1);
        chk("single_lo", 64'(lo), 64'h0);

        // Wrap: ptr=3 after a lane-2 grant, req=1001 -> lane 3 then lane 0.
        do_op(4'b1001, 1'b0, 1'b1);
        do_op(4'b1001, 1'b0, 1'b1);

        // Max operands on lane 0.
        wait_idle();
        la[0] = 32'hFFFF_FFFF;
        lb[0] = 32'hFFFF_FFFF;
        do_op(4'b0001, 1'b0, 1'b0);
        wait_drain();
        chk("max_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("max_lo", 64'(lo), 64'h0000_0001);

        // Flush in BUSY at cycle 2: no done, hi/lo untouched, ptr advanced.
        wait_drain();
        wait_idle();
        ph = m_hi;
        pl = m_lo;
        la[1] = 32'd7;
        lb[1] = 32'd6;
        req = 4'b0010;
        drive_ops();
        #1;
        w = pick(4'b0010, m_ptr);
        chk("flush_gnt", 64'(gnt), 64'(LANES'(1) << w));
        m_ptr = (w + 1) % LANES;
        @(negedge clk);
        req = '0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_idle", 64'(busy), 64'(0));
        chk("flush_mul_en", 64'(mul_en), 64'(0));
        chk("flush_hi", 64'(hi), 64'(ph));
        chk("flush_lo", 64'(lo), 64'(pl));
        // Flush in IDLE with a request pending blocks the grant.
        req = 4'b0100;
        #1;
        chk("flush_idle_gnt", 64'(gnt), 64'(0));
        @(negedge clk);
        chk("flush_idle_nogrant", 64'(busy), 64'(0));
        flush = 1'b0;
        req   = '0;
        @(negedge clk);

        // Randomized traffic.
        for (int n = 0; n < 20; n++) begin
            do_op(LANES'($urandom_range(1, (1 << LANES) - 1)), 1'b0, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_drain();

        // Asynchronous reset mid-BUSY aborts the op.
        wait_idle();
        for (int l = 0; l < LANES; l++) begin
            la[l] = $urandom;
            lb[l] = $urandom;
        end
        req = 4'b1111;
        drive_ops();
        #1;
        w = pick(4'b1111, m_ptr);
        chk("rst_test_gnt", 64'(gnt), 64'(LANES'(1) << w));
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid_mul_en", 64'(mul_en), 64'(0));
        chk("rst_mid_mul_a",  64'(mul_a),  64'(0));
        chk("rst_mid_mul_b",  64'(mul_b),  64'(0));
        chk("rst_mid_hi",     64'(hi),     64'(0));
        chk("rst_mid_lo",     64'(lo),     64'(0));
        chk("rst_mid_done",   64'(done),   64'(0));
        chk("rst_mid_busy",   64'(busy),   64'(0));
        chk("rst_mid_gnt",    64'(gnt),    64'(0));
        m_ptr = 0;
        m_hi  = '0;
        m_lo  = '0;
        @(negedge clk);
        req = '0;
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("post_rst_busy", 64'(busy), 64'(0));
            chk("post_rst_gnt",  64'(gnt),  64'(0));
        end

        // After reset ptr is 0 again: req=1010 must pick lane 1.
        do_op(4'b1010, 1'b0, 1'b1);
        wait_drain();
        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 64'(sbq.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
